// File: rtl/pipeline_hazard_controller_if.sv
// Bus interface for pipeline_hazard_controller.
// The "slave" modport is the controller's view (hazard inputs in, stall/flush
// controls out); the "master" modport is the pipeline's view.
// Optional macro STALL_PERF_COUNTERS_EN adds the two stall-counter outputs.
interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR = 5
);
  logic [REG_ADDR-1:0] i_id_rs1_addr;
  logic [REG_ADDR-1:0] i_id_rs2_addr;
  logic                i_id_uses_rs1;
  logic                i_id_uses_rs2;
  logic                i_ex_mem_rd;
  logic [REG_ADDR-1:0] i_ex_reg_destination;
  logic                i_ex_redirect;
  logic                i_ma_mem_req;
  logic                i_dmem_ready;
  logic                o_pc_en;
  logic                o_pc_redirect;
  logic                o_ifid_en;
  logic                o_ifid_flush;
  logic                o_idex_en;
  logic                o_idex_flush;
  logic                o_exma_en;
  logic                o_mawb_en;
  logic                o_mem_timeout;
`ifdef STALL_PERF_COUNTERS_EN
  logic [31:0]         o_load_stall_cnt;
  logic [31:0]         o_mem_stall_cnt;

  modport master (
    output i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_mem_rd, i_ex_reg_destination, i_ex_redirect,
           i_ma_mem_req, i_dmem_ready,
    input  o_pc_en, o_pc_redirect, o_ifid_en, o_ifid_flush, o_idex_en,
           o_idex_flush, o_exma_en, o_mawb_en, o_mem_timeout,
           o_load_stall_cnt, o_mem_stall_cnt
  );

  modport slave (
    input  i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_mem_rd, i_ex_reg_destination, i_ex_redirect,
           i_ma_mem_req, i_dmem_ready,
    output o_pc_en, o_pc_redirect, o_ifid_en, o_ifid_flush, o_idex_en,
           o_idex_flush, o_exma_en, o_mawb_en, o_mem_timeout,
           o_load_stall_cnt, o_mem_stall_cnt
  );
`else
  modport master (
    output i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_mem_rd, i_ex_reg_destination, i_ex_redirect,
           i_ma_mem_req, i_dmem_ready,
    input  o_pc_en, o_pc_redirect, o_ifid_en, o_ifid_flush, o_idex_en,
           o_idex_flush, o_exma_en, o_mawb_en, o_mem_timeout
  );

  modport slave (
    input  i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_mem_rd, i_ex_reg_destination, i_ex_redirect,
           i_ma_mem_req, i_dmem_ready,
    output o_pc_en, o_pc_redirect, o_ifid_en, o_ifid_flush, o_idex_en,
           o_idex_flush, o_exma_en, o_mawb_en, o_mem_timeout
  );
`endif
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Priority each cycle: data-memory freeze, EX redirect, post-redirect
// squash of stale fetches, load-use bubble, normal flow.
// Optional macro STALL_PERF_COUNTERS_EN adds free-running stall counters.
module pipeline_hazard_controller #(
  parameter int IMEM_LATENCY = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int REG_ADDR     = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_hazard_controller_if.slave  bus
);
  localparam logic [0:0]  ST_RUN      = 1'b0;
  localparam logic [0:0]  ST_REDIRECT = 1'b1;
  localparam logic [3:0]  LP_LAT      = 4'(IMEM_LATENCY);
  localparam logic [15:0] LP_TIMEOUT  = 16'(MEM_TIMEOUT);

  logic [0:0]          r_fsm;
  logic [3:0]          r_rcnt;
  logic [15:0]         r_wcnt;
  logic                r_timeout;

  logic [REG_ADDR-1:0] w_ex_rd;
  logic                w_freeze;
  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_load_use;
  logic                w_case_redirect;
  logic                w_case_squash;
  logic                w_case_load;
  logic [15:0]         w_wcnt_inc;

  assign w_ex_rd    = bus.i_ex_reg_destination;
  assign w_freeze   = bus.i_ma_mem_req & ~bus.i_dmem_ready;
  assign w_rs1_hit  = bus.i_id_uses_rs1 & (w_ex_rd == bus.i_id_rs1_addr);
  assign w_rs2_hit  = bus.i_id_uses_rs2 & (w_ex_rd == bus.i_id_rs2_addr);
  assign w_load_use = bus.i_ex_mem_rd & (w_ex_rd != '0) & (w_rs1_hit | w_rs2_hit);

  // One-hot view of which priority case owns this cycle (freeze is w_freeze itself)
  assign w_case_redirect = ~w_freeze & bus.i_ex_redirect;
  assign w_case_squash   = ~w_freeze & ~bus.i_ex_redirect & (r_fsm == ST_REDIRECT);
  assign w_case_load     = ~w_freeze & ~bus.i_ex_redirect & (r_fsm == ST_RUN) & w_load_use;

  // The wait counter saturates at the timeout limit instead of wrapping
  assign w_wcnt_inc = (r_wcnt == LP_TIMEOUT) ? r_wcnt : r_wcnt + 16'd1;

  assign bus.o_mem_timeout = r_timeout;

  // Decode the active priority case into stage enables and flushes; reset forces free flow
  always_comb begin
    bus.o_pc_en       = 1'b1;
    bus.o_pc_redirect = 1'b0;
    bus.o_ifid_en     = 1'b1;
    bus.o_ifid_flush  = 1'b0;
    bus.o_idex_en     = 1'b1;
    bus.o_idex_flush  = 1'b0;
    bus.o_exma_en     = 1'b1;
    bus.o_mawb_en     = 1'b1;
    if (rst_n) begin
      if (w_freeze) begin
        bus.o_pc_en   = 1'b0;
        bus.o_ifid_en = 1'b0;
        bus.o_idex_en = 1'b0;
        bus.o_exma_en = 1'b0;
        bus.o_mawb_en = 1'b0;
      end else if (w_case_redirect) begin
        bus.o_pc_redirect = 1'b1;
        bus.o_ifid_flush  = 1'b1;
        bus.o_idex_flush  = 1'b1;
      end else if (w_case_squash) begin
        bus.o_ifid_flush = 1'b1;
      end else if (w_case_load) begin
        bus.o_pc_en      = 1'b0;
        bus.o_ifid_en    = 1'b0;
        bus.o_idex_flush = 1'b1;
      end
    end
  end

  // Sequencer state, memory wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= ST_RUN;
      r_rcnt    <= '0;
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (w_freeze) begin
      r_wcnt <= w_wcnt_inc;
      if (w_wcnt_inc == LP_TIMEOUT) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_wcnt <= '0;
      if (bus.i_ex_redirect) begin
        if (IMEM_LATENCY > 0) begin
          r_fsm  <= ST_REDIRECT;
          r_rcnt <= LP_LAT;
        end else begin
          r_fsm  <= ST_RUN;
          r_rcnt <= '0;
        end
      end else if (r_fsm == ST_REDIRECT) begin
        if (r_rcnt <= 4'd1) begin
          r_rcnt <= '0;
          r_fsm  <= ST_RUN;
        end else begin
          r_rcnt <= r_rcnt - 4'd1;
        end
      end
    end
  end

`ifdef STALL_PERF_COUNTERS_EN
  logic [31:0] r_load_cnt;
  logic [31:0] r_mem_cnt;

  assign bus.o_load_stall_cnt = r_load_cnt;
  assign bus.o_mem_stall_cnt  = r_mem_cnt;

  // Count cycles in which a load-use bubble or a memory freeze owns the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt <= '0;
      r_mem_cnt  <= '0;
    end else begin
      if (w_case_load) begin
        r_load_cnt <= r_load_cnt + 32'd1;
      end
      if (w_freeze) begin
        r_mem_cnt <= r_mem_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller (IMEM_LATENCY=2, MEM_TIMEOUT=4).
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;
  localparam int IMEM_LAT = 2;
  localparam int MEM_TO   = 4;
  localparam int RA       = 5;

  // Packed output order: {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exma_en, mawb_en}
  localparam logic [7:0] OUT_NORMAL = 8'b1010_1011;
  localparam logic [7:0] OUT_FREEZE = 8'b0000_0000;
  localparam logic [7:0] OUT_REDIR  = 8'b1111_1111;
  localparam logic [7:0] OUT_SQUASH = 8'b1011_1011;
  localparam logic [7:0] OUT_LOAD   = 8'b0000_1111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.REG_ADDR(RA)) bus ();

  pipeline_hazard_controller #(
    .IMEM_LATENCY(IMEM_LAT),
    .MEM_TIMEOUT (MEM_TO),
    .REG_ADDR    (RA)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       usesRs1;
    logic [4:0] rs1;
    logic       usesRs2;
    logic [4:0] rs2;
    logic       exLoad;
    logic [4:0] exRd;
    logic       redirect;
    logic       memReq;
    logic       ready;
    logic [7:0] expOut;
  } vecT;

  vecT vecs[12];

  // Reference model state: flush cycles still owed, consecutive wait cycles, sticky error, counters
  int          mFlushLeft;
  int          mWait;
  logic        mTimeout;
  logic [31:0] mLoadCnt;
  logic [31:0] mMemCnt;

  function automatic vecT mkVec(logic u1, logic [4:0] r1, logic u2, logic [4:0] r2,
                                logic ld, logic [4:0] rd, logic rdir, logic req,
                                logic rdy, logic [7:0] exp);
    vecT v;
    v.usesRs1 = u1; v.rs1 = r1; v.usesRs2 = u2; v.rs2 = r2;
    v.exLoad = ld; v.exRd = rd; v.redirect = rdir;
    v.memReq = req; v.ready = rdy; v.expOut = exp;
    return v;
  endfunction

  function automatic logic [7:0] packOut();
    return {bus.o_pc_en, bus.o_pc_redirect, bus.o_ifid_en, bus.o_ifid_flush,
            bus.o_idex_en, bus.o_idex_flush, bus.o_exma_en, bus.o_mawb_en};
  endfunction

  task automatic applyStimulus(input logic u1, input logic [4:0] r1, input logic u2,
                               input logic [4:0] r2, input logic ld, input logic [4:0] rd,
                               input logic rdir, input logic req, input logic rdy);
    bus.i_id_uses_rs1        = u1;
    bus.i_id_rs1_addr        = r1;
    bus.i_id_uses_rs2        = u2;
    bus.i_id_rs2_addr        = r2;
    bus.i_ex_mem_rd          = ld;
    bus.i_ex_reg_destination = rd;
    bus.i_ex_redirect        = rdir;
    bus.i_ma_mem_req         = req;
    bus.i_dmem_ready         = rdy;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = packOut();
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Advance to one time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyIdle();
    tick();
    tick();
    rst_n = 1'b1;
    mFlushLeft = 0;
    mWait      = 0;
    mTimeout   = 1'b0;
    mLoadCnt   = '0;
    mMemCnt    = '0;
  endtask

  // One randomized cycle: predict from the rules, compare, then advance the model and the clock
  task automatic randomCycle();
    logic       u1, u2, ld, rdir, req, rdy, frz, lu;
    logic [4:0] r1, r2, rd;
    logic [7:0] exp;
    u1   = 1'($urandom_range(0, 1));
    u2   = 1'($urandom_range(0, 1));
    r1   = 5'($urandom_range(0, 3));
    r2   = 5'($urandom_range(0, 3));
    rd   = 5'($urandom_range(0, 3));
    ld   = 1'($urandom_range(0, 1));
    rdir = ($urandom_range(0, 7) == 0);
    req  = ($urandom_range(0, 2) == 0);
    rdy  = 1'($urandom_range(0, 1));
    applyStimulus(u1, r1, u2, r2, ld, rd, rdir, req, rdy);
    #1;
    frz = req && !rdy;
    lu  = ld && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
    if (frz)                 exp = OUT_FREEZE;
    else if (rdir)           exp = OUT_REDIR;
    else if (mFlushLeft > 0) exp = OUT_SQUASH;
    else if (lu)             exp = OUT_LOAD;
    else                     exp = OUT_NORMAL;
    checkOutput("random outputs", exp);
    checkBit("random timeout", bus.o_mem_timeout, mTimeout);
`ifdef STALL_PERF_COUNTERS_EN
    checkWord("random load cnt", bus.o_load_stall_cnt, mLoadCnt);
    checkWord("random mem cnt", bus.o_mem_stall_cnt, mMemCnt);
`endif
    if (frz) begin
      mWait = (mWait + 1 > MEM_TO) ? MEM_TO : mWait + 1;
      if (mWait == MEM_TO) mTimeout = 1'b1;
      mMemCnt++;
    end else begin
      mWait = 0;
      if (rdir)                mFlushLeft = IMEM_LAT;
      else if (mFlushLeft > 0) mFlushLeft--;
      else if (lu)             mLoadCnt++;
    end
    @(posedge clk);
  endtask

  initial begin
    applyIdle();
    // Vectors are each applied from the RUN state with the pipeline idle
    vecs[0]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, OUT_NORMAL);
    vecs[1]  = mkVec(1, 5, 0, 0, 1, 5, 0, 0, 1, OUT_LOAD);
    vecs[2]  = mkVec(1, 0, 0, 0, 1, 0, 0, 0, 1, OUT_NORMAL);
    vecs[3]  = mkVec(0, 0, 1, 7, 1, 7, 0, 0, 1, OUT_LOAD);
    vecs[4]  = mkVec(0, 0, 0, 7, 1, 7, 0, 0, 1, OUT_NORMAL);
    vecs[5]  = mkVec(1, 5, 0, 0, 0, 5, 0, 0, 1, OUT_NORMAL);
    vecs[6]  = mkVec(0, 0, 0, 0, 0, 0, 1, 0, 1, OUT_REDIR);
    vecs[7]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1, 0, OUT_FREEZE);
    vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1, 1, OUT_NORMAL);
    vecs[9]  = mkVec(1, 5, 0, 0, 1, 5, 1, 1, 0, OUT_FREEZE);
    vecs[10] = mkVec(1, 5, 0, 0, 1, 5, 1, 0, 1, OUT_REDIR);
    vecs[11] = mkVec(1, 3, 1, 4, 1, 6, 0, 0, 0, OUT_NORMAL);

    // Reset state: free flow and no error, even with a freeze on the inputs
    rst_n = 1'b0;
    applyStimulus(1, 5, 0, 0, 1, 5, 1, 1, 0);
    #2;
    checkOutput("reset outputs", OUT_NORMAL);
    checkBit("reset timeout", bus.o_mem_timeout, 1'b0);
    doReset();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].usesRs1, vecs[i].rs1, vecs[i].usesRs2, vecs[i].rs2,
                    vecs[i].exLoad, vecs[i].exRd, vecs[i].redirect,
                    vecs[i].memReq, vecs[i].ready);
      #1;
      checkOutput($sformatf("vector %0d", i), vecs[i].expOut);
      tick();
      applyIdle();
      tick(); tick(); tick();
    end

    // Load-use is a single bubble: the next cycle has a bubble in EX
    doReset();
    applyStimulus(1, 5, 0, 0, 1, 5, 0, 0, 1);
    #1; checkOutput("loaduse bubble", OUT_LOAD);
    tick();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 1);
    #1; checkOutput("loaduse release", OUT_NORMAL);
    tick();

    // Redirect followed by exactly two squash cycles; load-use ignored while squashing
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    #1; checkOutput("redirect c0", OUT_REDIR);
    tick();
    applyStimulus(1, 5, 0, 0, 1, 5, 0, 0, 1);
    #1; checkOutput("redirect c1", OUT_SQUASH);
    tick();
    applyIdle();
    #1; checkOutput("redirect c2", OUT_SQUASH);
    tick();
    #1; checkOutput("redirect c3", OUT_NORMAL);
    tick();

    // Redirect during a squash restarts the squash window
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    #1; checkOutput("re-redirect", OUT_REDIR);
    tick();
    applyIdle();
    #1; checkOutput("re-redirect s1", OUT_SQUASH);
    tick();
    #1; checkOutput("re-redirect s2", OUT_SQUASH);
    tick();
    #1; checkOutput("re-redirect done", OUT_NORMAL);
    tick();

    // Freeze beats redirect and load-use; once ready, redirect wins and load-use is ignored
    applyStimulus(1, 5, 0, 0, 1, 5, 1, 1, 0);
    #1; checkOutput("combo freeze 1", OUT_FREEZE);
    tick();
    #1; checkOutput("combo freeze 2", OUT_FREEZE);
    tick();
    applyStimulus(1, 5, 0, 0, 1, 5, 1, 1, 1);
    #1; checkOutput("combo redirect", OUT_REDIR);
    tick();
    applyStimulus(1, 5, 0, 0, 1, 5, 0, 0, 1);
    #1; checkOutput("combo squash", OUT_SQUASH);
    tick();
    applyIdle();
    tick();

    // Freeze during a squash holds the remaining squash count
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); tick();
    applyIdle();
    #1; checkOutput("held squash 1", OUT_SQUASH);
    tick();
    #1; checkOutput("held squash 2", OUT_SQUASH);
    tick();
    #1; checkOutput("held squash done", OUT_NORMAL);

    // Wait counter clears on ready: 3 + 3 stalls never reach the limit of 4
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); tick(); tick();
    applyIdle();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); tick(); tick();
    #1; checkBit("no timeout after split stalls", bus.o_mem_timeout, 1'b0);
    applyIdle();
    tick();

    // Five-cycle freeze then ready; timeout rises after the 4th stall and is sticky
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 5; c++) begin
      #1;
      checkOutput($sformatf("freeze cycle %0d", c), OUT_FREEZE);
      checkBit($sformatf("timeout before edge %0d", c), bus.o_mem_timeout, (c > 4));
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1; checkOutput("freeze release", OUT_NORMAL);
    checkBit("timeout sticky", bus.o_mem_timeout, 1'b1);
`ifdef STALL_PERF_COUNTERS_EN
    checkWord("mem stall count", bus.o_mem_stall_cnt, 32'd5);
`endif
    tick();
    applyIdle();
    tick(); tick();
    checkBit("timeout still sticky", bus.o_mem_timeout, 1'b1);
    rst_n = 1'b0;
    #1; checkBit("timeout cleared by reset", bus.o_mem_timeout, 1'b0);
    doReset();

    // Reset while mid-squash returns straight to RUN with no flush
    applyStimulus(1, 5, 0, 0, 1, 5, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    applyIdle();
    tick();
    #1; checkOutput("pre-reset squash", OUT_SQUASH);
    rst_n = 1'b0;
    #1; checkOutput("reset mid-squash", OUT_NORMAL);
`ifdef STALL_PERF_COUNTERS_EN
    checkWord("reset load cnt", bus.o_load_stall_cnt, 32'd0);
    checkWord("reset mem cnt", bus.o_mem_stall_cnt, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    #1; checkOutput("after reset run", OUT_NORMAL);
    tick();

    // Randomized run against the behavioural model, with periodic resets
    for (int blk = 0; blk < 4; blk++) begin
      doReset();
      @(posedge clk);
      for (int n = 0; n < 150; n++) begin
        #1;
        randomCycle();
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MA, WB).
- Detects load-use hazards against the instruction in ID.
- Freezes the whole pipeline while data memory is not ready.
- Squashes wrong-path fetches after an EX-stage redirect (taken branch or jump), including instructions still in flight from a multi-cycle instruction memory.
- Drives the per-stage clock enables and synchronous flushes; o_idex_en/o_idex_flush connect to the decode stage's clk_en/i_flush.

Parameters:
- IMEM_LATENCY, 1, cycles of stale fetch data that arrive after a redirect (0..15).
- MEM_TIMEOUT, 255, consecutive memory-stall cycles before the timeout error is raised (1..65535).
- REG_ADDR, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_id_rs1_addr  in  REG_ADDR  rs1 field of the instruction in ID.
- i_id_rs2_addr  in  REG_ADDR  rs2 field of the instruction in ID.
- i_id_uses_rs1  in  1  instruction in ID reads rs1.
- i_id_uses_rs2  in  1  instruction in ID reads rs2.
- i_ex_mem_rd  in  1  instruction in EX is a load.
- i_ex_reg_destination  in  REG_ADDR  rd of the instruction in EX.
- i_ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- i_ma_mem_req  in  1  MA stage has a load/store outstanding.
- i_dmem_ready  in  1  data memory completes the MA access this cycle.
- o_pc_en  out  1  PC update enable.
- o_pc_redirect  out  1  PC selects the EX target.
- o_ifid_en  out  1  IF/ID register enable.
- o_ifid_flush  out  1  IF/ID register cleared to a bubble.
- o_idex_en  out  1  ID/EX enable (decode clk_en).
- o_idex_flush  out  1  ID/EX cleared to a bubble (decode i_flush).
- o_exma_en  out  1  EX/MA enable.
- o_mawb_en  out  1  MA/WB enable.
- o_mem_timeout  out  1  sticky memory-timeout error.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- All control outputs are combinational from the registered state and current inputs.
- Registered state: fsm, redirect counter rcnt (4 bits), wait counter wcnt (16 bits, saturating), and the sticky error flag.

Reset:
- fsm=RUN, rcnt=0, wcnt=0, o_mem_timeout=0.
- During reset all enables read 1 and both flushes read 0.
- Reset asserted mid-redirect or mid-stall abandons the operation immediately.

Conditions:
- freeze = i_ma_mem_req & ~i_dmem_ready.
- load_use = i_ex_mem_rd & (i_ex_reg_destination!=0) & ((i_id_uses_rs1 & rd==rs1) | (i_id_uses_rs2 & rd==rs2)).

Output priority, evaluated every cycle in either state:
1. freeze:
   - All enables=0, all flushes=0, o_pc_redirect=0.
   - fsm and rcnt are held.
   - wcnt increments, saturating at MEM_TIMEOUT. When wcnt reaches MEM_TIMEOUT, o_mem_timeout is set (sticky until reset).
2. Otherwise wcnt clears to 0 at the next edge. Then, in order:
   - i_ex_redirect:
     - o_pc_en=1, o_pc_redirect=1, o_ifid_flush=1, o_idex_flush=1, all other enables=1.
     - If IMEM_LATENCY>0: fsm<=REDIRECT, rcnt<=IMEM_LATENCY. Else fsm stays RUN.
     - A redirect arriving while in REDIRECT restarts rcnt.
   - fsm==REDIRECT:
     - o_ifid_flush=1 (squashes the stale fetch), o_pc_en=1, all other enables=1.
     - load_use is ignored.
     - rcnt decrements; when it reaches 0, fsm<=RUN (exactly IMEM_LATENCY flush cycles).
   - load_use (RUN only):
     - o_pc_en=0, o_ifid_en=0, o_idex_flush=1; o_idex_en, o_exma_en, o_mawb_en=1.
     - This inserts exactly one bubble; the hazard clears naturally the next cycle.
   - Else: all enables=1, flushes=0.

Other rules:
- A flush with enable=1 in the same cycle: the flush wins at the flushed register.
- rd==x0 never causes a stall.

Optional Feature:
Macro STALL_PERF_COUNTERS_EN.
- Defined adds outputs o_load_stall_cnt[31:0] and o_mem_stall_cnt[31:0]:
  - Free-running wrap-around counters.
  - Incremented on each cycle that load_use or freeze (respectively) is the active priority case.
  - Reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Load-use: EX load rd=x5, ID uses rs1=x5 -> exactly one cycle with o_pc_en=0, o_ifid_en=0, o_idex_flush=1, then all enables=1. Repeat with rd=x0 -> no stall.
- Redirect with IMEM_LATENCY=2: i_ex_redirect pulse -> cycle 0: o_pc_redirect=1, o_ifid_flush=1, o_idex_flush=1; cycles 1-2: o_ifid_flush=1 only; cycle 3: RUN with no flush.
- Memory freeze: i_ma_mem_req=1, i_dmem_ready=0 for 5 cycles, then 1 -> 5 cycles of all enables=0; 6th cycle all enables=1; wcnt back to 0.
- Simultaneous events: freeze + redirect + load_use in the same cycle -> freeze only; after ready, redirect outputs and load_use is ignored.
- Timeout with MEM_TIMEOUT=4: 6 stall cycles -> o_mem_timeout rises after the 4th stall cycle, stays 1 after ready, clears only on rst_n=0.
- Reset mid-REDIRECT: assert rst_n=0 while rcnt=1 -> immediately RUN, no flush; perf counters (if compiled in) read 0.
